// File: rtl/fp_class_pkg.sv
// Shared constants for the floating-point classifier pipeline.
// No logic; flag bit positions, counter indices and exponent bias helper.
// Imported by fp_class_lane and fp_class_pipe.
package fp_class_pkg;

  // One-hot class flag vector {snan,qnan,zero,inf,sub,norm}
  localparam int FLAG_WIDTH = 6;
  localparam int FLAG_SNAN  = 5;
  localparam int FLAG_QNAN  = 4;
  localparam int FLAG_ZERO  = 3;
  localparam int FLAG_INF   = 2;
  localparam int FLAG_SUB   = 1;
  localparam int FLAG_NORM  = 0;

  // Statistics counter slots
  localparam int NUM_CNT  = 4;
  localparam int CNT_NAN  = 0;
  localparam int CNT_INF  = 1;
  localparam int CNT_ZERO = 2;
  localparam int CNT_SUB  = 3;

  // IEEE-style exponent bias for an exponent field of the given width
  function automatic int fp_bias(input int exp_width);
    return (1 << (exp_width - 1)) - 1;
  endfunction

endpackage

// File: rtl/fp_class_lane.sv
// Single-operand classifier: one-hot class, sign, unbiased exponent, full significand.
// Latency: purely combinational.
// Backpressure: none; the caller registers the result.
module fp_class_lane
  import fp_class_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 7
) (
  input  logic [EXP_WIDTH+SIG_WIDTH:0] i_num,
  output logic [FLAG_WIDTH-1:0]        o_flag,
  output logic                         o_sign,
  output logic [EXP_WIDTH:0]           o_exp,
  output logic [SIG_WIDTH:0]           o_sig
);

  localparam int                 BIAS_I = fp_bias(EXP_WIDTH);
  localparam logic [EXP_WIDTH:0] BIAS   = (EXP_WIDTH+1)'(BIAS_I);
  localparam logic [EXP_WIDTH:0] ONE    = (EXP_WIDTH+1)'(1);

  logic [EXP_WIDTH-1:0] raw_exp;
  logic [SIG_WIDTH-1:0] raw_sig;
  logic                 exp_ones;
  logic                 exp_zero;
  logic                 sig_zero;

  assign o_sign   = i_num[EXP_WIDTH+SIG_WIDTH];
  assign raw_exp  = i_num[SIG_WIDTH +: EXP_WIDTH];
  assign raw_sig  = i_num[SIG_WIDTH-1:0];
  assign exp_ones = &raw_exp;
  assign exp_zero = ~|raw_exp;
  assign sig_zero = ~|raw_sig;

  // Decode class; subnormals and zeros share the minimum exponent 1-BIAS
  always_comb begin
    o_flag = '0;
    o_exp  = {1'b0, raw_exp} - BIAS;
    o_sig  = {1'b0, raw_sig};
    if (exp_ones) begin
      if (sig_zero) begin
        o_flag[FLAG_INF] = 1'b1;
      end else if (raw_sig[SIG_WIDTH-1]) begin
        o_flag[FLAG_QNAN] = 1'b1;
      end else begin
        o_flag[FLAG_SNAN] = 1'b1;
      end
    end else if (exp_zero) begin
      o_exp = ONE - BIAS;
      if (sig_zero) begin
        o_flag[FLAG_ZERO] = 1'b1;
      end else begin
        o_flag[FLAG_SUB] = 1'b1;
      end
    end else begin
      o_flag[FLAG_NORM] = 1'b1;
      o_sig             = {1'b1, raw_sig};
    end
  end

endmodule

// File: rtl/fp_class_pipe.sv
// Multi-lane FP classifier with per-class saturating lane statistics.
// Latency: 1 cycle from accepted input beat to o_valid.
// Backpressure: output reg + skid reg; registered o_ready drops only while skid is occupied.
module fp_class_pipe
  import fp_class_pkg::*;
#(
  parameter int EXP_WIDTH = 8,
  parameter int SIG_WIDTH = 7,
  parameter int LANES     = 4,
  parameter int CNT_WIDTH = 16,
  localparam int NUM_WIDTH = 1 + EXP_WIDTH + SIG_WIDTH
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_valid,
  output logic                            o_ready,
  input  logic [LANES*NUM_WIDTH-1:0]      i_data,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic [LANES*FLAG_WIDTH-1:0]     o_flag,
  output logic [LANES-1:0]                o_sign,
  output logic [LANES*(EXP_WIDTH+1)-1:0]  o_exp,
  output logic [LANES*(SIG_WIDTH+1)-1:0]  o_sig,
  input  logic                            i_cnt_clr,
  output logic [CNT_WIDTH-1:0]            o_cnt_nan,
  output logic [CNT_WIDTH-1:0]            o_cnt_inf,
  output logic [CNT_WIDTH-1:0]            o_cnt_zero,
  output logic [CNT_WIDTH-1:0]            o_cnt_sub
);

  localparam int EW1   = EXP_WIDTH + 1;
  localparam int SW1   = SIG_WIDTH + 1;
  localparam int PAY_W = LANES * (FLAG_WIDTH + 1 + EW1 + SW1);
  localparam int PCW   = $clog2(LANES + 1);
  localparam int SUMW  = ((CNT_WIDTH > PCW) ? CNT_WIDTH : PCW) + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // Combinational per-lane decode of the incoming beat
  logic [LANES*FLAG_WIDTH-1:0] dec_flag;
  logic [LANES-1:0]            dec_sign;
  logic [LANES*EW1-1:0]        dec_exp;
  logic [LANES*SW1-1:0]        dec_sig;
  logic [PAY_W-1:0]            pay_in;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    fp_class_lane #(
      .EXP_WIDTH (EXP_WIDTH),
      .SIG_WIDTH (SIG_WIDTH)
    ) u_lane (
      .i_num  (i_data[l*NUM_WIDTH +: NUM_WIDTH]),
      .o_flag (dec_flag[l*FLAG_WIDTH +: FLAG_WIDTH]),
      .o_sign (dec_sign[l]),
      .o_exp  (dec_exp[l*EW1 +: EW1]),
      .o_sig  (dec_sig[l*SW1 +: SW1])
    );
  end

  assign pay_in = {dec_sig, dec_exp, dec_sign, dec_flag};

  // Handshake state: output entry, skid entry, registered ready
  logic [PAY_W-1:0] out_q, out_d;
  logic             out_vld_q, out_vld_d;
  logic [PAY_W-1:0] skid_q, skid_d;
  logic             skid_vld_q, skid_vld_d;
  logic             rdy_q, rdy_d;
  logic             accept;
  logic             pop;

  assign accept = i_valid & rdy_q;
  assign pop    = out_vld_q & i_ready;

  // Next state of the two-entry buffer; skid drains first so order is kept
  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (skid_vld_q) begin
      // rdy_q is low here, so no accept can coincide with a full skid
      if (pop) begin
        out_d      = skid_q;
        skid_vld_d = 1'b0;
      end
    end else if (accept) begin
      if (!out_vld_q || pop) begin
        out_d     = pay_in;
        out_vld_d = 1'b1;
      end else begin
        skid_d     = pay_in;
        skid_vld_d = 1'b1;
      end
    end else if (pop) begin
      out_vld_d = 1'b0;
    end
    rdy_d = ~skid_vld_d;
  end

  // Buffer registers; ready comes up on the first edge after reset release
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
    end
  end

  assign o_ready = rdy_q;
  assign o_valid = out_vld_q;
  assign {o_sig, o_exp, o_sign, o_flag} = out_q;

  // Per-class lane population of the incoming beat (nan counts both kinds)
  logic [PCW-1:0] pc [NUM_CNT];

  always_comb begin
    for (int c = 0; c < NUM_CNT; c++) begin
      pc[c] = '0;
    end
    for (int l = 0; l < LANES; l++) begin
      pc[CNT_NAN]  = pc[CNT_NAN]  + PCW'(dec_flag[l*FLAG_WIDTH+FLAG_SNAN] |
                                         dec_flag[l*FLAG_WIDTH+FLAG_QNAN]);
      pc[CNT_INF]  = pc[CNT_INF]  + PCW'(dec_flag[l*FLAG_WIDTH+FLAG_INF]);
      pc[CNT_ZERO] = pc[CNT_ZERO] + PCW'(dec_flag[l*FLAG_WIDTH+FLAG_ZERO]);
      pc[CNT_SUB]  = pc[CNT_SUB]  + PCW'(dec_flag[l*FLAG_WIDTH+FLAG_SUB]);
    end
  end

  // Counter update: clear first, then add this beat's counts, saturating
  logic [CNT_WIDTH-1:0] cnt_q [NUM_CNT];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_CNT];
  logic [CNT_WIDTH-1:0] base;
  logic [SUMW-1:0]      sum;

  always_comb begin
    base = '0;
    sum  = '0;
    for (int c = 0; c < NUM_CNT; c++) begin
      base     = i_cnt_clr ? '0 : cnt_q[c];
      sum      = SUMW'(base) + SUMW'(pc[c]);
      cnt_d[c] = base;
      if (accept) begin
        cnt_d[c] = (sum > SUMW'(CNT_MAX)) ? CNT_MAX : sum[CNT_WIDTH-1:0];
      end
    end
  end

  // Counter registers, independent of output backpressure
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NUM_CNT; c++) begin
        cnt_q[c] <= '0;
      end
    end else begin
      for (int c = 0; c < NUM_CNT; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
    end
  end

  assign o_cnt_nan  = cnt_q[CNT_NAN];
  assign o_cnt_inf  = cnt_q[CNT_INF];
  assign o_cnt_zero = cnt_q[CNT_ZERO];
  assign o_cnt_sub  = cnt_q[CNT_SUB];

endmodule

// File: tb/tb_fp_class_pipe.sv
// Bench for fp_class_pipe in bf16 configuration with 4-bit counters.
// Inputs driven on the falling edge; outputs sampled 1ns later.
// Scoreboard queue holds expected beats in acceptance order.
module tb_fp_class_pipe;

  localparam int L  = 4;
  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_valid;
  logic          o_ready;
  logic [63:0]   i_data;
  logic          o_valid;
  logic          i_ready;
  logic [23:0]   o_flag;
  logic [3:0]    o_sign;
  logic [35:0]   o_exp;
  logic [31:0]   o_sig;
  logic          i_cnt_clr;
  logic [CW-1:0] o_cnt_nan;
  logic [CW-1:0] o_cnt_inf;
  logic [CW-1:0] o_cnt_zero;
  logic [CW-1:0] o_cnt_sub;

  always #5 i_clk = ~i_clk;

  fp_class_pipe #(
    .EXP_WIDTH (8),
    .SIG_WIDTH (7),
    .LANES     (L),
    .CNT_WIDTH (CW)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data     (i_data),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_flag     (o_flag),
    .o_sign     (o_sign),
    .o_exp      (o_exp),
    .o_sig      (o_sig),
    .i_cnt_clr  (i_cnt_clr),
    .o_cnt_nan  (o_cnt_nan),
    .o_cnt_inf  (o_cnt_inf),
    .o_cnt_zero (o_cnt_zero),
    .o_cnt_sub  (o_cnt_sub)
  );

  typedef struct packed {
    logic [23:0] flag;
    logic [3:0]  sign;
    logic [35:0] ex;
    logic [31:0] sg;
  } beat_t;

  beat_t sb_q[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    n_pop = 0;
  int    mc[4];          // nan, inf, zero, sub
  logic  hold_pend = 1'b0;
  beat_t held;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference bf16 classifier
  function automatic beat_t model(input logic [63:0] d);
    beat_t       b;
    logic [15:0] n;
    logic [7:0]  e;
    logic [6:0]  m;
    logic [5:0]  f;
    logic [8:0]  x;
    logic [7:0]  s;
    b = '0;
    for (int i = 0; i < L; i++) begin
      n = d[16*i +: 16];
      e = n[14:7];
      m = n[6:0];
      if (e == 8'hFF) begin
        x = 9'd128;
        s = {1'b0, m};
        f = (m == 7'd0) ? 6'b000100 : (m[6] ? 6'b010000 : 6'b100000);
      end else if (e == 8'h00) begin
        x = 9'h182;
        s = {1'b0, m};
        f = (m == 7'd0) ? 6'b001000 : 6'b000010;
      end else begin
        x = {1'b0, e} - 9'd127;
        s = {1'b1, m};
        f = 6'b000001;
      end
      b.flag[6*i +: 6] = f;
      b.sign[i]        = n[15];
      b.ex[9*i +: 9]   = x;
      b.sg[8*i +: 8]   = s;
    end
    return b;
  endfunction

  function automatic int sat_add(input int a, input int b);
    return (a + b > CMAX) ? CMAX : a + b;
  endfunction

  function automatic logic [15:0] rnum();
    logic [7:0] e;
    logic [6:0] m;
    e = 8'($urandom_range(1, 254));
    m = 7'($urandom_range(0, 127));
    case ($urandom_range(0, 5))
      0: ;
      1: begin e = 8'h00; m = 7'($urandom_range(1, 127)); end
      2: begin e = 8'h00; m = 7'd0; end
      3: begin e = 8'hFF; m = 7'd0; end
      4: begin e = 8'hFF; m = {1'b1, 6'($urandom_range(0, 63))}; end
      default: begin e = 8'hFF; m = {1'b0, 6'($urandom_range(1, 63))}; end
    endcase
    return {1'($urandom_range(0, 1)), e, m};
  endfunction

  function automatic logic [63:0] rbeat();
    return {rnum(), rnum(), rnum(), rnum()};
  endfunction

  // One cycle: drive, sample, score; accept/pop happen at the following rising edge
  task automatic cycle(input logic v, input logic [63:0] d, input logic r,
                       input logic c, output logic acc);
    beat_t cur;
    beat_t eb;
    beat_t nb;
    @(negedge i_clk);
    i_valid   = v;
    i_data    = d;
    i_ready   = r;
    i_cnt_clr = c;
    #1;
    cur = {o_flag, o_sign, o_exp, o_sig};
    chk("o_ready", 128'(o_ready), 128'(sb_q.size() < 2));
    chk("o_valid", 128'(o_valid), 128'(sb_q.size() != 0));
    chk("cnt_nan",  128'(o_cnt_nan),  128'(mc[0]));
    chk("cnt_inf",  128'(o_cnt_inf),  128'(mc[1]));
    chk("cnt_zero", 128'(o_cnt_zero), 128'(mc[2]));
    chk("cnt_sub",  128'(o_cnt_sub),  128'(mc[3]));
    if (hold_pend) chk("hold", 128'(cur), 128'(held));
    hold_pend = o_valid && !r;
    held      = cur;
    acc = v && o_ready;
    if (c) begin
      for (int k = 0; k < 4; k++) mc[k] = 0;
    end
    if (acc) begin
      nb = model(d);
      sb_q.push_back(nb);
      for (int i = 0; i < L; i++) begin
        mc[0] = sat_add(mc[0], int'(nb.flag[6*i+5] | nb.flag[6*i+4]));
        mc[1] = sat_add(mc[1], int'(nb.flag[6*i+2]));
        mc[2] = sat_add(mc[2], int'(nb.flag[6*i+3]));
        mc[3] = sat_add(mc[3], int'(nb.flag[6*i+1]));
      end
    end
    if (o_valid && r && sb_q.size() != 0) begin
      eb = sb_q.pop_front();
      n_pop++;
      chk("out_flag", 128'(o_flag), 128'(eb.flag));
      chk("out_sign", 128'(o_sign), 128'(eb.sign));
      chk("out_exp",  128'(o_exp),  128'(eb.ex));
      chk("out_sig",  128'(o_sig),  128'(eb.sg));
    end
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    #1;
    chk("rst_valid", 128'(o_valid), 128'(0));
    chk("rst_cnt", 128'({o_cnt_nan, o_cnt_inf, o_cnt_zero, o_cnt_sub}), 128'(0));
    chk("rst_data", 128'({o_flag, o_sign, o_exp, o_sig}), 128'(0));
    sb_q.delete();
    for (int k = 0; k < 4; k++) mc[k] = 0;
    hold_pend = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
  endtask

  task automatic drain();
    logic acc;
    for (int k = 0; k < 10 && sb_q.size() != 0; k++) cycle(1'b0, 64'h0, 1'b1, 1'b0, acc);
    chk("drain", 128'(sb_q.size()), 128'(0));
  endtask

  logic [63:0] beat_a;
  logic [63:0] beat_b;
  logic [63:0] burst [6];

  initial begin
    logic acc;
    int   sent;
    int   cyc;
    int   pop0;
    int   low;
    i_rst_n   = 1'b0;
    i_valid   = 1'b0;
    i_ready   = 1'b1;
    i_data    = '0;
    i_cnt_clr = 1'b0;
    beat_a = {16'h7F81, 16'h7FC0, 16'h0001, 16'h3F80};
    beat_b = {16'h4040, 16'h0000, 16'h8000, 16'hFF80};
    do_reset();

    // Directed class decode
    cycle(1'b1, beat_a, 1'b1, 1'b0, acc);
    cycle(1'b0, 64'h0,  1'b1, 1'b0, acc);
    chk("A_flag", 128'(o_flag), 128'({6'b100000, 6'b010000, 6'b000010, 6'b000001}));
    chk("A_exp",  128'(o_exp),  128'({9'd128, 9'd128, 9'h182, 9'd0}));
    chk("A_sig",  128'(o_sig),  128'(32'h01400180));
    chk("A_cnt_nan", 128'(o_cnt_nan), 128'(2));
    chk("A_cnt_sub", 128'(o_cnt_sub), 128'(1));
    cycle(1'b1, beat_b, 1'b1, 1'b0, acc);
    cycle(1'b0, 64'h0,  1'b1, 1'b0, acc);
    chk("B_flag", 128'(o_flag), 128'({6'b000001, 6'b001000, 6'b001000, 6'b000100}));
    chk("B_sign", 128'(o_sign), 128'(4'b0011));
    chk("B_exp3", 128'(o_exp[35:27]), 128'(9'd1));
    chk("B_sig3", 128'(o_sig[31:24]), 128'(8'hC0));
    chk("B_cnt_zero", 128'(o_cnt_zero), 128'(2));
    chk("B_cnt_inf",  128'(o_cnt_inf),  128'(1));

    // Burst with downstream stall in cycles 2..4
    for (int k = 0; k < 6; k++) burst[k] = rbeat();
    sent = 0; cyc = 0; low = 0; pop0 = n_pop;
    while (sent < 6 && cyc < 30) begin
      cyc++;
      cycle(1'b1, burst[sent], !(cyc >= 2 && cyc <= 4), 1'b0, acc);
      if (!o_ready) low++;
      if (acc) sent++;
    end
    chk("burst_sent", 128'(sent), 128'(6));
    chk("burst_rdy_low", 128'(low), 128'(3));
    drain();
    chk("burst_out", 128'(n_pop - pop0), 128'(6));

    // Random traffic with random backpressure and occasional clears
    for (int k = 0; k < 300; k++) begin
      cycle($urandom_range(0, 3) != 0, rbeat(), $urandom_range(0, 3) != 0,
            $urandom_range(0, 31) == 0, acc);
    end
    drain();

    // Saturation, then clear-with-accept
    cycle(1'b0, 64'h0, 1'b1, 1'b1, acc);
    for (int k = 0; k < 5; k++) cycle(1'b1, 64'h0, 1'b1, 1'b0, acc);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, acc);
    chk("sat_zero", 128'(o_cnt_zero), 128'(15));
    cycle(1'b1, {16'h3F80, 16'h3F80, 16'h3F80, 16'h0000}, 1'b1, 1'b1, acc);
    cycle(1'b0, 64'h0, 1'b1, 1'b0, acc);
    chk("clr_add_zero", 128'(o_cnt_zero), 128'(1));
    drain();

    // Reset with both entries full
    cycle(1'b1, beat_a, 1'b0, 1'b0, acc);
    cycle(1'b1, beat_b, 1'b0, 1'b0, acc);
    cycle(1'b0, 64'h0,  1'b0, 1'b0, acc);
    chk("full_rdy", 128'(o_ready), 128'(0));
    do_reset();
    cycle(1'b1, beat_b, 1'b1, 1'b0, acc);
    chk("post_rst_acc", 128'(acc), 128'(1));
    cycle(1'b0, 64'h0, 1'b1, 1'b0, acc);
    chk("post_rst_lat", 128'(o_valid), 128'(1));
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
